// File: rtl/mdc_pkg.sv
// Shared definitions for the subtractive GCD sequencer: FSM state type,
// default datapath width and small arithmetic helpers.
package mdc_pkg;

    localparam int MDC_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdc_state_e;

    // Result when at least one operand is zero: the other operand
    // (or zero if both are zero).
    function automatic logic [MDC_W-1:0] zero_res(input logic [MDC_W-1:0] a,
                                                  input logic [MDC_W-1:0] b);
        return a | b;
    endfunction

endpackage

// File: rtl/mdc_dp.sv
// Datapath for the subtractive GCD: operand registers with load and
// subtract enables, magnitude comparators, zero detects and a saturating
// step counter.
module mdc_dp
    import mdc_pkg::*;
#(
    parameter int W = MDC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         sub_a,
    input  logic         sub_b,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] a_val,
    output logic [W-1:0] b_val,
    output logic [W-1:0] steps_val,
    output logic         a_gt_b,
    output logic         b_gt_a,
    output logic         a_eq_b,
    output logic         a_zero,
    output logic         b_zero
);

    localparam logic [W-1:0] ZERO_W = {W{1'b0}};
    localparam logic [W-1:0] ONES_W = {W{1'b1}};
    localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [W-1:0] steps_q, steps_d;

    // Next-state logic for the operands and the saturating step counter.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        steps_d = steps_q;
        if (load) begin
            a_d     = i_a;
            b_d     = i_b;
            steps_d = ZERO_W;
        end else if (sub_a) begin
            a_d     = a_q - b_q;
            steps_d = (steps_q == ONES_W) ? steps_q : (steps_q + ONE_W);
        end else if (sub_b) begin
            b_d     = b_q - a_q;
            steps_d = (steps_q == ONES_W) ? steps_q : (steps_q + ONE_W);
        end else begin
            a_d     = a_q;
            b_d     = b_q;
            steps_d = steps_q;
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= ZERO_W;
            b_q     <= ZERO_W;
            steps_q <= ZERO_W;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            steps_q <= steps_d;
        end
    end

    assign a_val     = a_q;
    assign b_val     = b_q;
    assign steps_val = steps_q;
    assign a_gt_b    = (a_q > b_q);
    assign b_gt_a    = (b_q > a_q);
    assign a_eq_b    = (a_q == b_q);
    assign a_zero    = (a_q == ZERO_W);
    assign b_zero    = (b_q == ZERO_W);

endmodule

// File: rtl/mdc_seq.sv
// Subtractive GCD sequencer: IDLE/CALC/DONE control FSM with registered
// result outputs, driving the mdc_dp datapath.
module mdc_seq
    import mdc_pkg::*;
#(
    parameter int W = MDC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         ready,
    output logic         done,
    output logic [W-1:0] res,
    output logic [W-1:0] steps,
    output logic         err
);

    localparam logic [W-1:0] ZERO_W = {W{1'b0}};

    mdc_state_e   state_q, state_d;
    logic [W-1:0] res_q, res_d;
    logic [W-1:0] steps_q, steps_d;
    logic         err_q, err_d;
    logic         done_q, done_d;

    logic         load_s;
    logic         sub_a_s;
    logic         sub_b_s;
    logic [W-1:0] a_s;
    logic [W-1:0] b_s;
    logic [W-1:0] dp_steps_s;
    logic         a_gt_b_s;
    logic         b_gt_a_s;
    logic         a_eq_b_s;
    logic         a_zero_s;
    logic         b_zero_s;

    mdc_dp #(.W(W)) u_dp (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .sub_a     (sub_a_s),
        .sub_b     (sub_b_s),
        .i_a       (i_a),
        .i_b       (i_b),
        .a_val     (a_s),
        .b_val     (b_s),
        .steps_val (dp_steps_s),
        .a_gt_b    (a_gt_b_s),
        .b_gt_a    (b_gt_a_s),
        .a_eq_b    (a_eq_b_s),
        .a_zero    (a_zero_s),
        .b_zero    (b_zero_s)
    );

    // FSM transitions, datapath control and next values of the result registers.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        steps_d = steps_q;
        err_d   = err_q;
        done_d  = 1'b0;
        load_s  = 1'b0;
        sub_a_s = 1'b0;
        sub_b_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_s  = 1'b1;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (a_zero_s || b_zero_s) begin
                    // The low W bits of MDC_W-wide zero_res are exactly a|b for any W <= MDC_W.
                    res_d   = a_s | b_s;
                    err_d   = a_zero_s && b_zero_s;
                    steps_d = dp_steps_s;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (a_eq_b_s) begin
                    res_d   = a_s;
                    err_d   = 1'b0;
                    steps_d = dp_steps_s;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (a_gt_b_s) begin
                    sub_a_s = 1'b1;
                end else if (b_gt_a_s) begin
                    sub_b_s = 1'b1;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset overrides everything, including a running CALC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            res_q   <= ZERO_W;
            steps_q <= ZERO_W;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            steps_q <= steps_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = done_q;
    assign res   = res_q;
    assign steps = steps_q;
    assign err   = err_q;

endmodule

// File: tb/tb_mdc_seq.sv
// Self-checking bench for mdc_seq: Euclid-by-division reference model with
// a per-cycle comparator, plus directed vectors with hand-computed results.
module tb_mdc_seq;

    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] i_a   = '0;
    logic [W-1:0] i_b   = '0;
    logic         ready;
    logic         done;
    logic [W-1:0] res;
    logic [W-1:0] steps;
    logic         err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mdc_seq #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .i_a   (i_a),
        .i_b   (i_b),
        .ready (ready),
        .done  (done),
        .res   (res),
        .steps (steps),
        .err   (err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: GCD via remainders.
    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned x = a, y = b, r;
        while (y != 0) begin
            r = x % y;
            x = y;
            y = r;
        end
        return x[W-1:0];
    endfunction

    // Reference: subtraction count = sum of Euclid quotients minus the final
    // equal-operands step (zero when an operand is zero).
    function automatic logic [W-1:0] ref_steps(input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned x, y, r, s;
        if (a == 0 || b == 0) return '0;
        x = (a > b) ? a : b;
        y = (a > b) ? b : a;
        s = 0;
        while (y != 0) begin
            s = s + x / y;
            r = x % y;
            x = y;
            y = r;
        end
        return W'(s - 1);
    endfunction

    // Model state: edge counter, busy window and held outputs.
    int           e       = 0;
    int           done_at = -10;
    bit           busy    = 1'b0;
    logic [W-1:0] p_res   = '0, p_steps = '0;
    logic         p_err   = 1'b0;
    logic [W-1:0] m_res   = '0, m_steps = '0;
    logic         m_err   = 1'b0;
    bit           chk_en  = 1'b0;
    bit           exp_done;

    always @(posedge clk) begin
        e <= e + 1;
        if (rst) begin
            busy    <= 1'b0;
            m_res   <= '0;
            m_steps <= '0;
            m_err   <= 1'b0;
            done_at <= -10;
        end else if (busy) begin
            if (e == done_at) begin
                m_res   <= p_res;
                m_steps <= p_steps;
                m_err   <= p_err;
            end
            if (e == done_at + 1) busy <= 1'b0;
        end else if (start) begin
            busy    <= 1'b1;
            p_res   <= ref_gcd(i_a, i_b);
            p_steps <= ref_steps(i_a, i_b);
            p_err   <= (i_a == 0) && (i_b == 0);
            done_at <= e + int'(ref_steps(i_a, i_b)) + 1;
        end
    end

    // Per-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            exp_done = busy && (e == done_at + 1);
            check("ready", {63'd0, ready}, {63'd0, !busy});
            check("done", {63'd0, done}, {63'd0, exp_done});
            if (!busy || exp_done) begin
                check("res", {32'd0, res}, {32'd0, m_res});
                check("steps", {32'd0, steps}, {32'd0, m_steps});
                check("err", {63'd0, err}, {63'd0, m_err});
            end
        end
    end

    // Directed run with hand-computed expectations. pulse_at: cycle at which a
    // spurious start is pulsed during CALC (0 = none). start_in_done: hold start
    // high during the done cycle.
    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] xr, input logic [W-1:0] xs, input logic xe,
                       input int pulse_at, input bit start_in_done);
        int lat;
        bit got;
        @(negedge clk);
        i_a = a; i_b = b; start = 1'b1;
        check("ready_before_start", {63'd0, ready}, 64'd1);
        @(negedge clk);
        start = 1'b0; i_a = '0; i_b = '0;
        lat = 1;
        got = 1'b0;
        while (lat <= 200 && !got) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (lat == pulse_at) begin
                    start = 1'b1; i_a = 100; i_b = 10;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                lat++;
            end
        end
        start = 1'b0;
        check("done_seen", {63'd0, got}, 64'd1);
        if (got) begin
            check("latency", 64'(lat), 64'(2 + xs));
            check("res_lit", {32'd0, res}, {32'd0, xr});
            check("steps_lit", {32'd0, steps}, {32'd0, xs});
            check("err_lit", {63'd0, err}, {63'd0, xe});
        end
        if (start_in_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", {63'd0, done}, 64'd0);
        check("ready_after_done", {63'd0, ready}, 64'd1);
        check("res_hold", {32'd0, res}, {32'd0, xr});
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_ready", {63'd0, ready}, 64'd1);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_res", {32'd0, res}, 64'd0);
        check("reset_steps", {32'd0, steps}, 64'd0);
        check("reset_err", {63'd0, err}, 64'd0);

        run(32'd12,   32'd18,  32'd6,  32'd2,  1'b0, 0, 1'b0);
        run(32'd35,   32'd14,  32'd7,  32'd3,  1'b0, 0, 1'b1);
        run(32'd7,    32'd7,   32'd7,  32'd0,  1'b0, 0, 1'b0);
        run(32'd0,    32'd5,   32'd5,  32'd0,  1'b0, 0, 1'b0);
        run(32'd5,    32'd0,   32'd5,  32'd0,  1'b0, 0, 1'b0);
        run(32'd0,    32'd0,   32'd0,  32'd0,  1'b1, 0, 1'b0);
        run(32'd1071, 32'd462, 32'd21, 32'd11, 1'b0, 0, 1'b0);
        run(32'd13,   32'd1,   32'd1,  32'd12, 1'b0, 5, 1'b0);

        // Reset in the 5th CALC cycle of a long computation.
        @(negedge clk);
        i_a = 32'd1000; i_b = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_ready", {63'd0, ready}, 64'd1);
        check("rst_res", {32'd0, res}, 64'd0);
        check("rst_steps", {32'd0, steps}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        repeat (3) @(negedge clk);

        run(32'd9, 32'd6, 32'd3, 32'd2, 1'b0, 0, 1'b0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mdc_seq.md
MDC_SEQ -- requirements
Module: mdc_seq

Interface
REQ-001 Parameter W, default 32: operand, result and step-counter width in bits.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to compute; sampled only while ready=1.
REQ-005 i_a  input  W  first operand, unsigned; captured on the accepted start.
REQ-006 i_b  input  W  second operand, unsigned; captured on the accepted start.
REQ-007 ready  output  1  high in IDLE only; block can accept start.
REQ-008 done  output  1  one-cycle pulse; res, steps and err are valid.
REQ-009 res  output  W  greatest common divisor of the captured operands.
REQ-010 steps  output  W  number of subtraction cycles used; saturates at all-ones.
REQ-011 err  output  1  high when both captured operands were zero.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-013 IDLE with start=1 SHALL capture i_a into register a and i_b into register b, clear the step count, and move to CALC on the next edge.
REQ-014 Start SHALL be ignored in CALC and DONE; the captured operands SHALL stay unaffected.
REQ-015 In CALC, if a=0 or b=0, the block SHALL set res=a|b and err=(a==0 && b==0), then go to DONE.
REQ-016 In CALC, if a==b and a!=0, the block SHALL set res=a and err=0, then go to DONE.
REQ-017 In CALC, if a>b, the block SHALL perform a<=a-b, increment steps, and remain in CALC; one subtraction per cycle.
REQ-018 In CALC, if b>a, the block SHALL perform b<=b-a, increment steps, and remain in CALC.
REQ-019 Comparisons and subtractions SHALL be unsigned W-bit; no underflow is possible, because only the larger operand is reduced.
REQ-020 The steps counter SHALL saturate at 2^W-1 and SHALL NOT wrap.
REQ-021 DONE SHALL assert done for exactly one cycle and then go to IDLE.
REQ-022 Latency SHALL be 2+N cycles from the start-sampling edge to the first cycle with done high, where N is the final steps value.
REQ-023 res, steps and err SHALL hold their values from DONE until the next accepted start.
REQ-024 If start=1 during the done cycle, it SHALL be ignored; start is accepted only once ready=1 again.
REQ-025 ready SHALL be combinational from the state (ready=1 iff state==IDLE).

Reset
REQ-026 While rst=1 on a clock edge, the block SHALL set: state=IDLE, a=0, b=0, res=0, steps=0, err=0, done=0.
REQ-027 rst SHALL take priority over start and over any in-progress CALC; an interrupted computation produces no done pulse.
REQ-028 The first start after rst deasserts SHALL be accepted normally.

Structure
REQ-029 Shared package mdc_pkg SHALL hold the state enum type (IDLE, CALC, DONE) and the default width constant MDC_W=32.
REQ-030 The datapath SHALL be a single sub-module, mdc_dp, containing:
- registers a and b with load/subtract enables;
- the comparators a>b, b>a, a==b and the zero detects;
- the steps counter.
REQ-031 The FSM and output registers SHALL reside in mdc_seq.

Verification
REQ-032 Start with i_a=12, i_b=18 -> res=6, steps=2, err=0; done high in the 4th cycle after the start edge.
REQ-033 Start with 35, 14 -> res=7, steps=3; start with 7, 7 -> res=7, steps=0, done 2 cycles after start.
REQ-034 Start with 0, 5 -> res=5, err=0, steps=0; start with 0, 0 -> res=0, err=1, steps=0.
REQ-035 Start with 13, 1 -> res=1, steps=12; start pulsed with 100, 10 in mid-CALC -> ignored, result still res=1.
REQ-036 Start with 1000, 1; assert rst on the 5th CALC cycle -> no done pulse, all outputs 0, ready=1 next cycle; then 9, 6 -> res=3, steps=2.
